// File: rtl/router_input_buffer_if.sv
// Handshake bundle between one router input port, its upstream link, the arbiter and the crossbar.
interface router_input_buffer_if #(
  parameter int DATA_W = 32,
  parameter int LEN_W  = 12
);
  logic              in_valid;
  logic [DATA_W-1:0] in_data;
  logic [2:0]        in_flit_id;
  logic              in_ready;
  logic              grant;
  logic              req;
  logic [2:0]        flit_id;
  logic [LEN_W-1:0]  length;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic [2:0]        out_flit_id;
  logic              out_ready;
  logic              err;

  modport master (
    output in_valid, in_data, in_flit_id, grant, out_ready,
    input  in_ready, req, flit_id, length, out_valid, out_data, out_flit_id, err
  );

  modport slave (
    input  in_valid, in_data, in_flit_id, grant, out_ready,
    output in_ready, req, flit_id, length, out_valid, out_data, out_flit_id, err
  );
endinterface

// File: rtl/router_input_buffer.sv
// Router input port: flit FIFO with packet-framing FSM feeding the arbiter and crossbar.
// Optional ROUTER_PKT_CNT_EN adds a saturating forwarded-packet counter output.
module router_input_buffer #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 4,
  parameter int LEN_W  = 12
) (
  input  logic clk,
  input  logic rst,
  router_input_buffer_if.slave bus
`ifdef ROUTER_PKT_CNT_EN
  ,
  output logic [15:0] pkt_count
`endif
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [2:0] FLIT_HDR  = 3'b001;
  localparam logic [2:0] FLIT_TAIL = 3'b100;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_SEND} state_e;

  logic [DATA_W-1:0] mem_data_q [DEPTH];
  logic [2:0]        mem_id_q   [DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q;
  state_e            state_q, state_d;
  logic [LEN_W-1:0]  length_q, length_d;

  logic              empty, full, push, pop, drop;
  logic              req, out_valid, tail_fwd;
  logic [DATA_W-1:0] head_data;
  logic [2:0]        head_id;

  assign empty     = (count_q == '0);
  assign full      = (count_q == CW'(DEPTH));
  assign head_data = mem_data_q[rd_ptr_q];
  assign head_id   = mem_id_q[rd_ptr_q];
  assign push      = bus.in_valid & ~full;
  assign pop       = (out_valid & bus.out_ready) | drop;
  assign tail_fwd  = out_valid & bus.out_ready & (head_id == FLIT_TAIL);

  always_comb begin
    state_d   = state_q;
    length_d  = length_q;
    req       = 1'b0;
    out_valid = 1'b0;
    drop      = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (!empty) begin
          if (head_id == FLIT_HDR) begin
            length_d = head_data[LEN_W-1:0];
            state_d  = S_WAIT;
          end else begin
            drop = 1'b1;
          end
        end
      end
      S_WAIT: begin
        req = 1'b1;
        if (bus.grant) state_d = S_SEND;
      end
      S_SEND: begin
        req       = 1'b1;
        out_valid = bus.grant & ~empty;
        // Losing grant parks the packet in WAIT with the remaining flits still buffered.
        if (!bus.grant)    state_d = S_WAIT;
        else if (tail_fwd) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      length_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      state_q  <= state_d;
      length_q <= length_d;
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      count_q <= count_q + CW'(1);
      else if (!push && pop) count_q <= count_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem_data_q[wr_ptr_q] <= bus.in_data;
      mem_id_q[wr_ptr_q]   <= bus.in_flit_id;
    end
  end

`ifdef ROUTER_PKT_CNT_EN
  logic [15:0] pkt_count_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                              pkt_count_q <= '0;
    else if (tail_fwd && pkt_count_q != '1) pkt_count_q <= pkt_count_q + 16'd1;
  end

  assign pkt_count = pkt_count_q;
`endif

  assign bus.in_ready    = ~full;
  assign bus.req         = req;
  assign bus.flit_id     = empty ? 3'b000 : head_id;
  assign bus.length      = length_q;
  assign bus.out_valid   = out_valid;
  assign bus.out_data    = head_data;
  assign bus.out_flit_id = head_id;
  assign bus.err         = drop;
endmodule

// File: tb/tb_router_input_buffer.sv
// Bench for router_input_buffer: directed framing scenarios then random traffic against a queue model.
module tb_router_input_buffer;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int LEN_W  = 12;

  typedef struct {
    logic [31:0] data;
    logic [2:0]  id;
  } flit_t;

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  flit_t       q[$];
  bit          m_in_pkt;
  bit          m_sending;
  logic [11:0] m_len;
  logic [15:0] m_cnt;

  router_input_buffer_if #(.DATA_W(DATA_W), .LEN_W(LEN_W)) bus ();

`ifdef ROUTER_PKT_CNT_EN
  logic [15:0] pkt_count;
`endif

  router_input_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH), .LEN_W(LEN_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
`ifdef ROUTER_PKT_CNT_EN
    ,
    .pkt_count (pkt_count)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] time limit reached");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic void model_reset();
    q.delete();
    m_in_pkt  = 1'b0;
    m_sending = 1'b0;
    m_len     = '0;
    m_cnt     = '0;
  endfunction

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_req"},      32'(bus.req), 0);
    chk({tag, "_ovalid"},   32'(bus.out_valid), 0);
    chk({tag, "_inready"},  32'(bus.in_ready), 1);
    chk({tag, "_flitid"},   32'(bus.flit_id), 0);
    chk({tag, "_length"},   32'(bus.length), 0);
    chk({tag, "_err"},      32'(bus.err), 0);
  endtask

  // One clock cycle: drive, compare combinational outputs with the model, advance the model.
  task automatic step(input bit v, input logic [31:0] d, input logic [2:0] id,
                      input bit g, input bit ordy);
    bit    empty, exp_inr, exp_ov, exp_err, popped, tail_out;
    flit_t head;
    bus.in_valid   = v;
    bus.in_data    = d;
    bus.in_flit_id = id;
    bus.grant      = g;
    bus.out_ready  = ordy;
    #2;
    empty   = (q.size() == 0);
    if (!empty) head = q[0];
    exp_inr = (q.size() < DEPTH);
    exp_ov  = m_sending && g && !empty;
    exp_err = !m_in_pkt && !empty && head.id != 3'b001;
    chk("in_ready", 32'(bus.in_ready), 32'(exp_inr));
    chk("req",      32'(bus.req), 32'(m_in_pkt));
    chk("flit_id",  32'(bus.flit_id), empty ? 32'd0 : 32'(head.id));
    chk("length",   32'(bus.length), 32'(m_len));
    chk("out_valid", 32'(bus.out_valid), 32'(exp_ov));
    chk("err",      32'(bus.err), 32'(exp_err));
    if (!empty) begin
      chk("out_flit_id", 32'(bus.out_flit_id), 32'(head.id));
      chk("out_data",    bus.out_data, head.data);
    end
`ifdef ROUTER_PKT_CNT_EN
    chk("pkt_count", 32'(pkt_count), 32'(m_cnt));
`endif
    popped   = (exp_ov && ordy) || exp_err;
    tail_out = exp_ov && ordy && head.id == 3'b100;
    if (!m_in_pkt) begin
      if (!empty && head.id == 3'b001) begin
        m_in_pkt = 1'b1;
        m_len    = head.data[11:0];
      end
    end else if (!m_sending) begin
      if (g) m_sending = 1'b1;
    end else if (!g) begin
      m_sending = 1'b0;
    end else if (tail_out) begin
      m_in_pkt  = 1'b0;
      m_sending = 1'b0;
    end
    if (tail_out && m_cnt != 16'hFFFF) m_cnt = m_cnt + 16'd1;
    if (popped) void'(q.pop_front());
    if (v && exp_inr) q.push_back('{data: d, id: id});
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n, input bit g, input bit ordy);
    for (int i = 0; i < n; i++) step(1'b0, '0, 3'b000, g, ordy);
  endtask

  task automatic send_pkt(input logic [11:0] len, input int nbody);
    step(1'b1, {20'hA5000, len}, 3'b001, 1'b1, 1'b1);
    for (int i = 0; i < nbody; i++) step(1'b1, 32'hB000_0000 + 32'(i), 3'b010, 1'b1, 1'b1);
    step(1'b1, 32'hCAFE_0000 + 32'(len), 3'b100, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
  endtask

  initial begin
    int r;
    logic [2:0] rid;
    tests = 0;
    fails = 0;
    model_reset();
    bus.in_valid   = 1'b0;
    bus.in_data    = '0;
    bus.in_flit_id = '0;
    bus.grant      = 1'b0;
    bus.out_ready  = 1'b0;
    rst = 1'b1;
    #1;
    check_reset_outputs("reset");
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // basic packet, grant arriving after the header is claimed
    step(1'b1, 32'h0000_0003, 3'b001, 1'b0, 1'b1);
    step(1'b1, 32'h1111_1111, 3'b010, 1'b0, 1'b1);
    step(1'b1, 32'h2222_2222, 3'b100, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    chk("t1_length", 32'(bus.length), 32'd3);

    // fill to full with grant low; fifth offer refused; one pop frees a slot
    step(1'b1, 32'h0000_0007, 3'b001, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 32'h3000_0000 + 32'(i), 3'b010, 1'b0, 1'b1);
    chk("t2_full", 32'(bus.in_ready), 0);
    step(1'b0, '0, 3'b000, 1'b1, 1'b0);
    step(1'b0, '0, 3'b000, 1'b1, 1'b1);
    idle(6, 1'b1, 1'b1);
    step(1'b1, 32'h3333_3333, 3'b100, 1'b1, 1'b1);
    idle(4, 1'b1, 1'b1);

    // stray body and tail while idle are dropped with err
    step(1'b1, 32'h4444_4444, 3'b010, 1'b0, 1'b1);
    step(1'b1, 32'h4444_5555, 3'b100, 1'b0, 1'b1);
    idle(4, 1'b0, 1'b1);

    // grant withdrawn after two flits, then restored
    step(1'b1, 32'h0000_0005, 3'b001, 1'b1, 1'b1);
    step(1'b1, 32'h5000_0001, 3'b010, 1'b1, 1'b1);
    step(1'b1, 32'h5000_0002, 3'b010, 1'b1, 1'b1);
    step(1'b1, 32'h5000_0003, 3'b010, 1'b0, 1'b1);
    step(1'b1, 32'h5000_0004, 3'b100, 1'b0, 1'b1);
    idle(3, 1'b0, 1'b1);
    idle(8, 1'b1, 1'b1);

    // asynchronous reset in the middle of a packet
    step(1'b1, 32'h0000_0009, 3'b001, 1'b1, 1'b1);
    step(1'b1, 32'h6000_0001, 3'b010, 1'b1, 1'b1);
    step(1'b1, 32'h6000_0002, 3'b010, 1'b1, 1'b0);
    rst = 1'b1;
    #1;
    check_reset_outputs("async_rst");
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    send_pkt(12'd2, 1);

`ifdef ROUTER_PKT_CNT_EN
    send_pkt(12'd4, 2);
    send_pkt(12'd1, 0);
    chk("cnt_three", 32'(pkt_count), 32'(m_cnt));
    force dut.pkt_count_q = 16'hFFFF;
    #1;
    release dut.pkt_count_q;
    m_cnt = 16'hFFFF;
    send_pkt(12'd6, 1);
    chk("cnt_sat", 32'(pkt_count), 32'hFFFF);
`endif

    // random traffic
    for (int c = 0; c < 1500; c++) begin
      r = int'($urandom_range(0, 9));
      rid = (r < 2) ? 3'b001 : (r < 8) ? 3'b010 : 3'b100;
      step(($urandom_range(0, 3) != 0), $urandom, rid,
           ($urandom_range(0, 4) != 0), ($urandom_range(0, 3) != 0));
    end
    idle(10, 1'b1, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
